// File: rtl/hazard_scheduler_if.sv
// Stage-control bus between the decode/pipeline datapath and the hazard scheduler.
// The master side supplies hazard sources; the slave side returns stage enables and counters.
interface hazard_scheduler_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
);
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [20:0]       ex_ctrl;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_branch_taken;
  logic              mem_access;
  logic              mem_ready;

  logic              pc_en;
  logic              ifid_en;
  logic              ifid_flush;
  logic              idex_en;
  logic              idex_bubble;
  logic              exmem_en;
  logic              memwb_bubble;
  logic              mem_timeout_err;
  logic [CNT_W-1:0]  stall_count;
  logic [CNT_W-1:0]  flush_count;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_ctrl, ex_rd, ex_branch_taken,
           mem_access, mem_ready,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_bubble,
           mem_timeout_err, stall_count, flush_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_ctrl, ex_rd, ex_branch_taken,
           mem_access, mem_ready,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_bubble,
           mem_timeout_err, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_scheduler.sv
// Per-cycle advance/hold/bubble/flush decisions for the 5-stage pipeline, with a
// data-memory hang detector and saturating stall/flush performance counters.
module hazard_scheduler #(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic              clock,
  input  logic              reset,
  hazard_scheduler_if.slave bus
);
  typedef enum logic [1:0] {StRun, StWait, StError} state_e;

  localparam logic [7:0] TimeoutCnt = 8'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic [REG_AW-1:0] rs1, rs2, rd;
  logic ex_load, hazard, mem_busy;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_bubble;

  assign rs1      = bus.id_rs1;
  assign rs2      = bus.id_rs2;
  assign rd       = bus.ex_rd;
  assign ex_load  = bus.ex_ctrl[19] & ~bus.ex_ctrl[18] & bus.ex_ctrl[20];
  assign hazard   = ex_load & (rd != '0) &
                    ((bus.id_use_rs1 & (rs1 == rd)) | (bus.id_use_rs2 & (rs2 == rd)));
  assign mem_busy = bus.mem_access & ~bus.mem_ready;

  // Priority: error/memory freeze, then taken branch, then load-use bubble.
  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_en      = 1'b1;
    idex_bubble  = 1'b0;
    exmem_en     = 1'b1;
    memwb_bubble = 1'b0;
    if (state_q == StError || mem_busy) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
    end else if (bus.ex_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (hazard) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    stall_d    = stall_q;
    flush_d    = flush_q;
    unique case (state_q)
      StRun: begin
        if (mem_busy) begin
          state_d    = StWait;
          wait_cnt_d = 8'd1;
        end
      end
      StWait: begin
        if (!mem_busy) begin
          state_d    = StRun;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == TimeoutCnt) begin
          state_d = StError;
          err_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      StError: ;
      default: state_d = StRun;
    endcase
    // ERROR cycles are excluded from the stall statistic; both counters saturate.
    if (state_q != StError && !pc_en && !(&stall_q)) stall_d = stall_q + CNT_W'(1);
    if (ifid_flush && !(&flush_q)) flush_d = flush_q + CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StRun;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
      stall_q    <= '0;
      flush_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
    end
  end

  // Stage controls are forced idle while reset is held.
  assign bus.pc_en           = reset & pc_en;
  assign bus.ifid_en         = reset & ifid_en;
  assign bus.ifid_flush      = reset & ifid_flush;
  assign bus.idex_en         = reset & idex_en;
  assign bus.idex_bubble     = reset & idex_bubble;
  assign bus.exmem_en        = reset & exmem_en;
  assign bus.memwb_bubble    = reset & memwb_bubble;
  assign bus.mem_timeout_err = err_q;
  assign bus.stall_count     = stall_q;
  assign bus.flush_count     = flush_q;
endmodule
